id_ex_execute_stage: RTL

//  Consumer end of the ID/EX pipeline register: reads the latched operands, control,

---
 rtl/riscv_ex_pkg.sv | 32 +++
 rtl/ex_seq_multiplier.sv | 70 +++++++
 rtl/id_ex_execute_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_ex_pkg.sv
// Shared definitions for the execute stage: funct3 codes, control bit
// positions and the stage FSM encoding.
package riscv_ex_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int CTL_ALU_SRC_IMM = 4;
    localparam int CTL_IS_MUL      = 3;
    localparam int CTL_BRANCH      = 2;
    localparam int CTL_MEM_READ    = 1;
    localparam int CTL_MEM_WRITE   = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_seq_multiplier.sv
// Shift-add multiplier producing the low DATA_LEN bits of a*b.
// Always runs exactly DATA_LEN iterations; done pulses with the final sum.
module ex_seq_multiplier #(
    parameter int DATA_LEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                kill,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic                done,
    output logic [DATA_LEN-1:0] product
);
    localparam int CNT_W = $clog2(DATA_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_LEN - 1);

    logic                run_q, run_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_LEN-1:0] a_q, a_d;
    logic [DATA_LEN-1:0] b_q, b_d;
    logic [DATA_LEN-1:0] acc_q, acc_d;
    logic [DATA_LEN-1:0] sum;

    assign sum     = acc_q + (b_q[0] ? a_q : '0);
    assign product = sum;
    assign done    = run_q && (cnt_q == LAST);

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (kill) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            a_d   = a;
            b_d   = b;
            acc_d = '0;
        end else if (run_q) begin
            acc_d = sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/id_ex_execute_stage.sv
// Execute stage fed by the ID/EX register: single-cycle ALU and branch
// resolution, sequential MUL, valid/ready towards EX/MEM.
module id_ex_execute_stage
    import riscv_ex_pkg::*;
#(
    parameter int DATA_LEN          = 64,
    parameter int CONTROL_LINE_OUT  = 5,
    parameter int ADDRESS_SIZE      = 6,
    parameter int INSTRUCTION_1_LEN = 4,
    parameter int INSTRUCTION_2_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CONTROL_LINE_OUT-1:0]  control_out,
    input  logic [DATA_LEN-1:0]          data_1_out,
    input  logic [DATA_LEN-1:0]          data_2_out,
    input  logic [DATA_LEN-1:0]          imm_val_out,
    input  logic [2**ADDRESS_SIZE-1:0]   instruction_ptr_out,
    input  logic [INSTRUCTION_1_LEN-1:0] instruction_part_1_out,
    input  logic [INSTRUCTION_2_LEN-1:0] instruction_part_2_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_LEN-1:0]          alu_result,
    output logic [DATA_LEN-1:0]          store_data,
    output logic                         branch_taken,
    output logic [2**ADDRESS_SIZE-1:0]   branch_target,
    output logic [INSTRUCTION_2_LEN-1:0] rd_out,
    output logic                         mem_read_o,
    output logic                         mem_write_o,
    output logic                         busy
);
    localparam int PC_W = 2 ** ADDRESS_SIZE;
    localparam int SH_W = $clog2(DATA_LEN);

    ex_state_e                    state_q, state_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0]          alu_result_q, alu_result_d;
    logic [DATA_LEN-1:0]          store_data_q, store_data_d;
    logic                         branch_taken_q, branch_taken_d;
    logic [PC_W-1:0]              branch_target_q, branch_target_d;
    logic [INSTRUCTION_2_LEN-1:0] rd_q, rd_d;
    logic                         mem_read_q, mem_read_d;
    logic                         mem_write_q, mem_write_d;

    logic [2:0]          f3;
    logic                f7b5;
    logic                use_imm;
    logic [DATA_LEN-1:0] op_b;
    logic [SH_W-1:0]     shamt;
    logic [DATA_LEN-1:0] sra_res;
    logic [DATA_LEN-1:0] alu_res;
    logic                br_cond;
    logic                accept;
    logic                mul_start;
    logic                mul_done;
    logic [DATA_LEN-1:0] mul_product;

    assign f3      = instruction_part_1_out[2:0];
    assign f7b5    = instruction_part_1_out[3];
    assign use_imm = control_out[CTL_ALU_SRC_IMM];
    assign op_b    = use_imm ? imm_val_out : data_2_out;
    assign shamt   = op_b[SH_W-1:0];
    // kept apart so the arithmetic shift is not forced unsigned by a mux
    assign sra_res = $signed(data_1_out) >>> shamt;

    always_comb begin
        alu_res = '0;
        unique case (f3)
            F3_ADD:  alu_res = (f7b5 && !use_imm) ? data_1_out - op_b
                                                  : data_1_out + op_b;
            F3_SLL:  alu_res = data_1_out << shamt;
            F3_SLT:  alu_res = {{(DATA_LEN-1){1'b0}},
                                $signed(data_1_out) < $signed(op_b)};
            F3_SLTU: alu_res = {{(DATA_LEN-1){1'b0}}, data_1_out < op_b};
            F3_XOR:  alu_res = data_1_out ^ op_b;
            F3_SRL:  alu_res = f7b5 ? sra_res : data_1_out >> shamt;
            F3_OR:   alu_res = data_1_out | op_b;
            F3_AND:  alu_res = data_1_out & op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        unique case (f3)
            F3_BEQ:  br_cond = data_1_out == data_2_out;
            F3_BNE:  br_cond = data_1_out != data_2_out;
            F3_BLT:  br_cond = $signed(data_1_out) < $signed(data_2_out);
            F3_BGE:  br_cond = $signed(data_1_out) >= $signed(data_2_out);
            F3_BLTU: br_cond = data_1_out < data_2_out;
            F3_BGEU: br_cond = data_1_out >= data_2_out;
            default: br_cond = 1'b0;
        endcase
    end

    assign in_ready = rst && (state_q == IDLE)
                      && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    ex_seq_multiplier #(
        .DATA_LEN(DATA_LEN)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .kill   (flush),
        .a      (data_1_out),
        .b      (op_b),
        .done   (mul_done),
        .product(mul_product)
    );

    always_comb begin
        state_d         = state_q;
        out_valid_d     = out_valid_q;
        alu_result_d    = alu_result_q;
        store_data_d    = store_data_q;
        branch_taken_d  = branch_taken_q;
        branch_target_d = branch_target_q;
        rd_d            = rd_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mul_start       = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        store_data_d    = data_2_out;
                        branch_taken_d  = control_out[CTL_BRANCH] && br_cond;
                        branch_target_d = instruction_ptr_out
                                          + imm_val_out[PC_W-1:0];
                        rd_d            = instruction_part_2_out;
                        mem_read_d      = control_out[CTL_MEM_READ];
                        mem_write_d     = control_out[CTL_MEM_WRITE];
                        if (control_out[CTL_IS_MUL]) begin
                            state_d   = MUL_BUSY;
                            mul_start = 1'b1;
                        end else begin
                            alu_result_d = control_out[CTL_BRANCH] ? '0
                                                                   : alu_res;
                            out_valid_d  = 1'b1;
                        end
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        alu_result_d = mul_product;
                        out_valid_d  = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            out_valid_q     <= 1'b0;
            alu_result_q    <= '0;
            store_data_q    <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            rd_q            <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            rd_q            <= rd_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign alu_result    = alu_result_q;
    assign store_data    = store_data_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign rd_out        = rd_q;
    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;
    assign busy          = (state_q == MUL_BUSY);

endmodule
